// File: rtl/program_loader.sv
// program_loader
//  Assembles an MSB-first byte stream into NB_DATA-bit instruction words and
//  writes them sequentially into IF instruction memory. After the end-of-program
//  word it pulses the pipeline reset, then gates the pipeline through o_halt
//  for continuous runs or single steps until the pipeline reports HALT retired.
//  Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte
//  verified after HALT_WORD; adds the o_chk_err port).
//
//  Handshake: i_rx_valid is a one-cycle strobe with no back-pressure; a byte is
//  consumed on every clock where i_rx_valid is high in IDLE, LOAD or WRITE and
//  is dropped in every other state. o_we_IF is a one-cycle write strobe that
//  is qualified by o_instr_addr and o_instruction_data in the same cycle.
module program_loader #(
   parameter int                 NB_DATA         = 32,
   parameter int                 NB_BYTE         = 8,
   parameter int                 NB_ADDR         = 8,
   parameter logic [NB_DATA-1:0] HALT_WORD       = 32'hFFFF_FFFF,
   parameter int                 PIPE_RST_CYCLES = 2
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic [NB_BYTE-1:0] i_rx_data,
   input  logic               i_rx_valid,
   input  logic               i_start,
   input  logic               i_step,
   input  logic               i_pipe_halted,
   input  logic               i_clear,
   output logic               o_we_IF,
   output logic [NB_DATA-1:0] o_instruction_data,
   output logic [NB_ADDR-1:0] o_instr_addr,
   output logic [NB_ADDR:0]   o_word_count,
   output logic               o_pipe_rst_n,
   output logic               o_halt,
   output logic               o_overflow,
   output logic               o_done,
`ifdef LOADER_CHECKSUM_EN
   output logic               o_chk_err,
`endif
   output logic [2:0]         o_state
);

   localparam int NW  = NB_DATA / NB_BYTE;
   localparam int BCW = $clog2(NW + 1);
   localparam int FCW = $clog2(PIPE_RST_CYCLES + 1);
   localparam int CW  = NB_ADDR + 1;
   localparam logic [NB_ADDR-1:0] ADDR_MAX = '1;

`ifdef LOADER_CHECKSUM_EN
   // CHECK has its own code internally but is reported as 3 on o_state.
   typedef enum logic [3:0] {
      IDLE = 4'd0, LOAD = 4'd1, WRITE = 4'd2, FLUSH = 4'd3,
      READY = 4'd4, RUN = 4'd5, STEP = 4'd6, DONE = 4'd7, CHECK = 4'd8
   } state_e;
`else
   typedef enum logic [2:0] {
      IDLE = 3'd0, LOAD = 3'd1, WRITE = 3'd2, FLUSH = 3'd3,
      READY = 3'd4, RUN = 3'd5, STEP = 3'd6, DONE = 3'd7
   } state_e;
`endif

   state_e             state_q, state_d;
   logic [NB_DATA-1:0] acc_q, acc_d, acc_shift;
   logic [NB_DATA-1:0] data_q, data_d;
   logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
   logic [NB_ADDR-1:0] addr_q, addr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [FCW-1:0]     flush_cnt_q, flush_cnt_d;
   logic               overflow_q, overflow_d;
   logic               we_q, we_d;
   logic               prst_q, prst_d;
   logic               halt_q, halt_d;
   logic               done_q, done_d;
   logic [2:0]         state_dbg_q, state_dbg_d;
   logic               rx_accept;
`ifdef LOADER_CHECKSUM_EN
   logic [NB_BYTE-1:0] xor_q, xor_d;
   logic               chk_err_q, chk_err_d;
`endif

   assign rx_accept = i_rx_valid && (state_q == IDLE || state_q == LOAD || state_q == WRITE);
   assign acc_shift = (acc_q << NB_BYTE) | NB_DATA'(i_rx_data);

   // Next-state, datapath and registered-output decode for the loader/run FSM.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      data_d      = data_q;
      byte_cnt_d  = byte_cnt_q;
      addr_d      = addr_q;
      count_d     = count_q;
      flush_cnt_d = flush_cnt_q;
      overflow_d  = overflow_q;
`ifdef LOADER_CHECKSUM_EN
      xor_d       = xor_q;
      chk_err_d   = chk_err_q;
`endif
      if (i_clear) begin
         state_d    = IDLE;
         byte_cnt_d = '0;
         addr_d     = '0;
         count_d    = '0;
         overflow_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
         xor_d      = '0;
         chk_err_d  = 1'b0;
`endif
      end else begin
         if (rx_accept) begin
            acc_d      = acc_shift;
            byte_cnt_d = byte_cnt_q + BCW'(1);
`ifdef LOADER_CHECKSUM_EN
            xor_d      = xor_q ^ i_rx_data;
`endif
         end
         case (state_q)
            IDLE, LOAD: begin
               if (rx_accept) begin
                  if (byte_cnt_q == BCW'(NW - 1)) begin
                     data_d     = acc_shift;
                     byte_cnt_d = '0;
                     state_d    = WRITE;
                  end else begin
                     state_d    = LOAD;
                  end
               end
            end
            WRITE: begin
               count_d = count_q + CW'(1);
               if (addr_q != ADDR_MAX) addr_d = addr_q + NB_ADDR'(1);
               if (data_q == HALT_WORD) begin
                  flush_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                  state_d     = CHECK;
`else
                  state_d     = FLUSH;
`endif
               end else if (addr_q == ADDR_MAX) begin
                  overflow_d  = 1'b1;
                  flush_cnt_d = '0;
                  state_d     = FLUSH;
               end else begin
                  state_d     = LOAD;
               end
            end
            FLUSH: begin
               if (flush_cnt_q == FCW'(PIPE_RST_CYCLES - 1)) state_d = READY;
               else flush_cnt_d = flush_cnt_q + FCW'(1);
            end
            READY: begin
               if (i_start)     state_d = RUN;
               else if (i_step) state_d = STEP;
            end
            RUN: begin
               if (i_pipe_halted) state_d = DONE;
            end
            STEP: begin
               state_d = i_pipe_halted ? DONE : READY;
            end
            DONE: begin
               state_d = DONE;
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
               if (i_rx_valid) begin
                  if (i_rx_data == xor_q) begin
                     flush_cnt_d = '0;
                     state_d     = FLUSH;
                  end else begin
                     chk_err_d   = 1'b1;
                     state_d     = DONE;
                  end
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end
      // Control outputs are decoded from the next state so they are registered
      // and line up with o_state in the same cycle.
      we_d   = (state_d == WRITE);
      prst_d = (state_d != FLUSH);
      halt_d = !(state_d == RUN || state_d == STEP);
      done_d = (state_d == DONE);
`ifdef LOADER_CHECKSUM_EN
      state_dbg_d = (state_d == CHECK) ? 3'd3 : state_d[2:0];
`else
      state_dbg_d = state_d;
`endif
   end

   // State and output registers; reset discards any partially assembled word.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         data_q      <= '0;
         byte_cnt_q  <= '0;
         addr_q      <= '0;
         count_q     <= '0;
         flush_cnt_q <= '0;
         overflow_q  <= 1'b0;
         we_q        <= 1'b0;
         prst_q      <= 1'b0;
         halt_q      <= 1'b1;
         done_q      <= 1'b0;
         state_dbg_q <= 3'd0;
`ifdef LOADER_CHECKSUM_EN
         xor_q       <= '0;
         chk_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         data_q      <= data_d;
         byte_cnt_q  <= byte_cnt_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         flush_cnt_q <= flush_cnt_d;
         overflow_q  <= overflow_d;
         we_q        <= we_d;
         prst_q      <= prst_d;
         halt_q      <= halt_d;
         done_q      <= done_d;
         state_dbg_q <= state_dbg_d;
`ifdef LOADER_CHECKSUM_EN
         xor_q       <= xor_d;
         chk_err_q   <= chk_err_d;
`endif
      end
   end

   assign o_we_IF            = we_q;
   assign o_instruction_data = data_q;
   assign o_instr_addr       = addr_q;
   assign o_word_count       = count_q;
   assign o_pipe_rst_n       = prst_q;
   assign o_halt             = halt_q;
   assign o_overflow         = overflow_q;
   assign o_done             = done_q;
   assign o_state            = state_dbg_q;
`ifdef LOADER_CHECKSUM_EN
   assign o_chk_err          = chk_err_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//  Randomized byte streams and run commands against program_loader. A timeline
//  model (expected value of every output per clock edge, filled in from the
//  loader's rules as stimulus is issued) plus a queue of expected memory words
//  is compared with the DUT every cycle. A second instance with NB_ADDR=2
//  covers memory overflow.
module tb_program_loader;

   localparam int          MAXE = 12000;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // ---------------- DUT (default parameters) ----------------
   logic [7:0]  rx_data;
   logic        rx_valid, start, step, pipe_halted, clear;
   logic        we_if, prst_n, halt, overflow, done;
   logic [31:0] instr_data;
   logic [7:0]  instr_addr;
   logic [8:0]  word_count;
   logic [2:0]  state;

   program_loader dut (
      .clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .i_start(start), .i_step(step), .i_pipe_halted(pipe_halted), .i_clear(clear),
      .o_we_IF(we_if), .o_instruction_data(instr_data), .o_instr_addr(instr_addr),
      .o_word_count(word_count), .o_pipe_rst_n(prst_n), .o_halt(halt),
      .o_overflow(overflow), .o_done(done), .o_state(state)
   );

   // ---------------- small DUT for overflow ----------------
   logic [7:0]  s_rx_data;
   logic        s_rx_valid, s_clear;
   logic        s_we, s_prst_n, s_halt, s_overflow, s_done;
   logic [31:0] s_data;
   logic [1:0]  s_addr;
   logic [2:0]  s_count;
   logic [2:0]  s_state;
   logic        s_zero;

   program_loader #(.NB_ADDR(2)) dut_small (
      .clk(clk), .i_rst_n(rst_n), .i_rx_data(s_rx_data), .i_rx_valid(s_rx_valid),
      .i_start(s_zero), .i_step(s_zero), .i_pipe_halted(s_zero), .i_clear(s_clear),
      .o_we_IF(s_we), .o_instruction_data(s_data), .o_instr_addr(s_addr),
      .o_word_count(s_count), .o_pipe_rst_n(s_prst_n), .o_halt(s_halt),
      .o_overflow(s_overflow), .o_done(s_done), .o_state(s_state)
   );

   // ---------------- scoreboard / report counters ----------------
   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model: expected outputs per edge ----------------
   logic [2:0]  st_a   [MAXE];
   bit          halt_a [MAXE];
   bit          prst_a [MAXE];
   bit          done_a [MAXE];
   bit          we_a   [MAXE];
   logic [31:0] data_a [MAXE];
   logic [8:0]  cnt_a  [MAXE];
   logic [7:0]  addr_a [MAXE];

   function automatic void set_st(input int e, input logic [2:0] v);
      for (int i = e; i < MAXE; i++) st_a[i] = v;
   endfunction
   function automatic void set_halt(input int e, input bit v);
      for (int i = e; i < MAXE; i++) halt_a[i] = v;
   endfunction
   function automatic void set_prst(input int e, input bit v);
      for (int i = e; i < MAXE; i++) prst_a[i] = v;
   endfunction
   function automatic void set_done(input int e, input bit v);
      for (int i = e; i < MAXE; i++) done_a[i] = v;
   endfunction
   function automatic void set_data(input int e, input logic [31:0] v);
      for (int i = e; i < MAXE; i++) data_a[i] = v;
   endfunction
   function automatic void set_cnt(input int e, input logic [8:0] v);
      for (int i = e; i < MAXE; i++) cnt_a[i] = v;
   endfunction
   function automatic void set_addr(input int e, input logic [7:0] v);
      for (int i = e; i < MAXE; i++) addr_a[i] = v;
   endfunction

   logic [7:0] bytes_q[$];
   bit         loading, idle;
   int         wr_n;

   // Reset released so that edge r+1 is the first active edge.
   function automatic void model_reset(input int r);
      for (int i = 0; i < MAXE; i++) we_a[i] = 1'b0;
      set_st(r, 3'd0); set_halt(r, 1'b1); set_done(r, 1'b0);
      set_prst(r, 1'b0); set_prst(r + 1, 1'b1);
      set_data(r, 32'h0); set_cnt(r, 9'd0); set_addr(r, 8'd0);
      bytes_q.delete(); exp_q.delete();
      loading = 1'b1; idle = 1'b1; wr_n = 0;
   endfunction

   // A byte sampled at edge s; four bytes make one MSB-first word.
   function automatic void model_byte(input logic [7:0] b, input int s);
      logic [31:0] w;
      if (!loading) return;
      if (idle) begin set_st(s, 3'd1); idle = 1'b0; end
      bytes_q.push_back(b);
      if (bytes_q.size() == 4) begin
         w = {bytes_q[0], bytes_q[1], bytes_q[2], bytes_q[3]};
         bytes_q.delete();
         exp_q.push_back(w);
         we_a[s] = 1'b1;
         set_data(s, w);
         set_st(s, 3'd2);
         set_cnt(s + 1, 9'(wr_n + 1));
         set_addr(s + 1, 8'(wr_n + 1));
         wr_n++;
         if (w == HALT) begin
            loading = 1'b0;
            set_st(s + 1, 3'd3); set_prst(s + 1, 1'b0);
            set_st(s + 3, 3'd4); set_prst(s + 3, 1'b1);
         end else begin
            set_st(s + 1, 3'd1);
         end
      end
   endfunction

   function automatic void model_clear(input int c);
      set_st(c, 3'd0); set_cnt(c, 9'd0); set_addr(c, 8'd0);
      set_done(c, 1'b0); set_halt(c, 1'b1);
      bytes_q.delete();
      loading = 1'b1; idle = 1'b1; wr_n = 0;
   endfunction

   // ---------------- compare process ----------------
   bit chk_en = 1'b0;
   int halt_lo_n = 0;
   int prst_lo_n = 0;

   always @(negedge clk) begin
      if (chk_en && edge_cnt < MAXE) begin
         check("state", 32'(state), 32'(st_a[edge_cnt]));
         check("halt", 32'(halt), 32'(halt_a[edge_cnt]));
         check("pipe_rst_n", 32'(prst_n), 32'(prst_a[edge_cnt]));
         check("done", 32'(done), 32'(done_a[edge_cnt]));
         check("we_IF", 32'(we_if), 32'(we_a[edge_cnt]));
         check("data", instr_data, data_a[edge_cnt]);
         check("count", 32'(word_count), 32'(cnt_a[edge_cnt]));
         check("addr", 32'(instr_addr), 32'(addr_a[edge_cnt]));
         check("overflow", 32'(overflow), 32'h0);
         if (we_a[edge_cnt] && exp_q.size() > 0) begin
            logic [31:0] w;
            w = exp_q.pop_front();
            if (we_if) check("sb_word", instr_data, w);
         end
         if (!halt) halt_lo_n++;
         if (!prst_n) prst_lo_n++;
      end
   end

   // ---------------- driver tasks (called just after a rising edge) ----------------
   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1;
      model_byte(b, edge_cnt + 1);
      tick(1);
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[31 - 8 * i -: 8]);
         tick($urandom_range(0, maxgap));
      end
   endtask

   task automatic do_step();
      int s;
      s = edge_cnt + 1;
      step = 1'b1;
      set_st(s, 3'd6); set_halt(s, 1'b0);
      set_st(s + 1, 3'd4); set_halt(s + 1, 1'b1);
      tick(1); step = 1'b0; tick(1);
   endtask

   task automatic do_step_halted();
      int s;
      s = edge_cnt + 1;
      step = 1'b1;
      set_st(s, 3'd6); set_halt(s, 1'b0);
      set_st(s + 1, 3'd7); set_halt(s + 1, 1'b1); set_done(s + 1, 1'b1);
      tick(1); step = 1'b0; pipe_halted = 1'b1; tick(1); pipe_halted = 1'b0;
   endtask

   task automatic do_start(input bit with_step);
      int s;
      s = edge_cnt + 1;
      start = 1'b1; step = with_step;
      set_st(s, 3'd5); set_halt(s, 1'b0);
      tick(1); start = 1'b0; step = 1'b0;
   endtask

   task automatic do_halted();
      int s;
      s = edge_cnt + 1;
      pipe_halted = 1'b1;
      set_st(s, 3'd7); set_halt(s, 1'b1); set_done(s, 1'b1);
      tick(1); pipe_halted = 1'b0;
   endtask

   task automatic poke_halted();
      pipe_halted = 1'b1; tick(1); pipe_halted = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      model_clear(edge_cnt + 1);
      tick(1); clear = 1'b0;
   endtask

   task automatic run_program(input int nwords);
      logic [31:0] w;
      for (int i = 0; i < nwords; i++) begin
         w = $urandom();
         if (w == HALT) w = 32'h0;
         send_word(w, 2);
      end
      send_word(HALT, 2);
      tick(4);
   endtask

   task automatic s_send_byte(input logic [7:0] b);
      s_rx_data = b; s_rx_valid = 1'b1; tick(1); s_rx_valid = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #(1_000_000);
      errors++;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] w;
      rx_data = '0; rx_valid = 1'b0; start = 1'b0; step = 1'b0;
      pipe_halted = 1'b0; clear = 1'b0;
      s_rx_data = '0; s_rx_valid = 1'b0; s_clear = 1'b0; s_zero = 1'b0;
      loading = 1'b1; idle = 1'b1; wr_n = 0;
      tick(3);
      // reset values while reset is held
      check("rst_state", 32'(state), 32'd0);
      check("rst_halt", 32'(halt), 32'd1);
      check("rst_prst", 32'(prst_n), 32'd0);
      check("rst_we", 32'(we_if), 32'd0);
      check("rst_data", instr_data, 32'h0);
      check("rst_count", 32'(word_count), 32'd0);
      rst_n = 1'b1;
      model_reset(edge_cnt);
      chk_en = 1'b1;
      tick(2);

      // single word, then the short ADDI/ADDI/ADDU program
      send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h14);
      check("t1_we", 32'(we_if), 32'd1);
      check("t1_data", instr_data, 32'h2001_0014);
      check("t1_addr", 32'(instr_addr), 32'd0);
      tick(1);
      check("t1_count", 32'(word_count), 32'd1);
      prst_lo_n = 0;
      send_word(32'h2002_001E, 0);
      send_word(32'h0022_1821, 1);
      send_word(HALT, 2);
      tick(4);
      check("t2_state", 32'(state), 32'd4);
      check("t2_halt", 32'(halt), 32'd1);
      check("t2_count", 32'(word_count), 32'd4);
      check("t2_prst_lo", 32'(prst_lo_n), 32'd2);

      // single steps, ignored inputs in READY, start+step together
      halt_lo_n = 0;
      repeat (3) do_step();
      check("t3_steps", 32'(halt_lo_n), 32'd3);
      send_byte(8'hAA);
      poke_halted();
      tick(1);
      check("t3_ready", 32'(state), 32'd4);
      do_start(1'b1);
      check("t3_run", 32'(state), 32'd5);
      tick($urandom_range(3, 10));
      do_halted();
      check("t4_done", 32'(done), 32'd1);
      check("t4_halt", 32'(halt), 32'd1);
      tick(3);
      do_clear();
      check("t4_idle", 32'(state), 32'd0);
      check("t4_count", 32'(word_count), 32'd0);
      check("t4_done0", 32'(done), 32'd0);

      // randomized programs and run modes
      for (int it = 0; it < 6; it++) begin
         if (it == 2) begin
            w = $urandom();
            if (w == HALT) w = 32'h1;
            send_word(w, 1);
            send_byte(8'h12); send_byte(8'h34);
            do_clear();
            tick(1);
         end
         run_program($urandom_range(1, 10));
         repeat ($urandom_range(0, 3)) do_step();
         if ($urandom_range(0, 1) == 1) begin
            do_start(1'b0);
            tick($urandom_range(1, 8));
            do_halted();
         end else begin
            do_step_halted();
         end
         tick(2);
         do_clear();
         tick(1);
      end

      // asynchronous reset in the middle of a word
      send_byte(8'h55); send_byte(8'h66);
      chk_en = 1'b0;
      rst_n = 1'b0;
      #2;
      check("t6_state", 32'(state), 32'd0);
      check("t6_prst", 32'(prst_n), 32'd0);
      check("t6_halt", 32'(halt), 32'd1);
      check("t6_count", 32'(word_count), 32'd0);
      check("t6_data", instr_data, 32'h0);
      tick(2);
      rst_n = 1'b1;
      model_reset(edge_cnt);
      chk_en = 1'b1;
      tick(1);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      check("t6_word", instr_data, 32'hDEAD_BEEF);
      check("t6_addr", 32'(instr_addr), 32'd0);
      tick(1);
      send_word(HALT, 1);
      tick(4);
      do_clear();
      tick(2);

      // overflow on a 4-word memory
      for (int i = 0; i < 4; i++) begin
         w = 32'h1000_0000 + 32'(i);
         for (int j = 0; j < 4; j++) s_send_byte(w[31 - 8 * j -: 8]);
         check("t5_we", 32'(s_we), 32'd1);
         check("t5_addr", 32'(s_addr), 32'(i));
         check("t5_data", s_data, w);
         check("t5_ovf_pre", 32'(s_overflow), 32'd0);
         tick(1);
      end
      check("t5_ovf", 32'(s_overflow), 32'd1);
      check("t5_flush", 32'(s_state), 32'd3);
      check("t5_nowrap", 32'(s_addr), 32'd3);
      check("t5_count", 32'(s_count), 32'd4);
      check("t5_prst", 32'(s_prst_n), 32'd0);
      tick(2);
      check("t5_ready", 32'(s_state), 32'd4);
      check("t5_ovf_sticky", 32'(s_overflow), 32'd1);
      s_clear = 1'b1; tick(1); s_clear = 1'b0;
      check("t5_clr_ovf", 32'(s_overflow), 32'd0);
      check("t5_clr_state", 32'(s_state), 32'd0);

      tick(3);
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
